// File: rtl/tile_match_if.sv
// Tile-match engine bus: decoded picks and start in, game status out.
// The engine uses the slave side; the keyboard/display glue uses the master side.
interface tile_match_if #(
    parameter int NUM_TILES = 10,
    parameter int COLOR_W   = 3,
    parameter int IDX_W     = 4,
    parameter int CNT_W     = 8
);
    logic                         start;
    logic                         pick_valid;
    logic [IDX_W-1:0]             pick_idx;
    logic [NUM_TILES*COLOR_W-1:0] tile_colors;
    logic [2:0]                   game_state;
    logic [NUM_TILES-1:0]         revealed;
    logic [NUM_TILES-1:0]         matched;
    logic [IDX_W-1:0]             first_idx;
    logic [IDX_W-1:0]             second_idx;
    logic                         match_pulse;
    logic                         miss_pulse;
    logic [CNT_W-1:0]             score;
    logic [CNT_W-1:0]             moves;
    logic                         game_over;

    modport master (
        output start, pick_valid, pick_idx, tile_colors,
        input  game_state, revealed, matched, first_idx, second_idx,
               match_pulse, miss_pulse, score, moves, game_over
    );

    modport slave (
        input  start, pick_valid, pick_idx, tile_colors,
        output game_state, revealed, matched, first_idx, second_idx,
               match_pulse, miss_pulse, score, moves, game_over
    );
endinterface

// File: rtl/tile_match_engine.sv
// Pair-matching game core: accepts tile picks, compares pairs against colours
// latched at game start, holds mismatches visible, and keeps score/move counts.
module tile_match_engine #(
    parameter int NUM_TILES     = 10,
    parameter int COLOR_W       = 3,
    parameter int IDX_W         = 4,
    parameter int MISMATCH_HOLD = 25000000,
    parameter int CNT_W         = 8
) (
    input logic        CLOCK_50,
    input logic        reset,
    tile_match_if.slave bus
);
    // Internal tile vectors span the whole index space so any IDX_W-wide index
    // selects a real bit; entries at or above NUM_TILES stay zero.
    localparam int TW     = 2 ** IDX_W;
    localparam int HOLD_W = (MISMATCH_HOLD > 1) ? $clog2(MISMATCH_HOLD) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FIRST  = 3'd1,
        S_SECOND = 3'd2,
        S_CMP    = 3'd3,
        S_HOLD   = 3'd4,
        S_OVER   = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [COLOR_W-1:0]   color_q [TW];
    logic [TW*COLOR_W-1:0] colors_pad;
    logic [TW-1:0]        revealed_q, matched_q;
    logic [IDX_W-1:0]     first_q, second_q;
    logic                 match_pulse_q, miss_pulse_q;
    logic [CNT_W-1:0]     score_q, moves_q;
    logic [HOLD_W-1:0]    hold_cnt;
    logic                 legal_pick, colors_equal, last_pair, hold_done;

    function automatic logic [TW-1:0] onehot(input logic [IDX_W-1:0] i);
        return TW'(1) << i;
    endfunction

    assign colors_pad   = (TW*COLOR_W)'(bus.tile_colors);
    assign legal_pick   = bus.pick_valid && (32'(bus.pick_idx) < NUM_TILES) &&
                          !revealed_q[bus.pick_idx] && !matched_q[bus.pick_idx];
    assign colors_equal = (color_q[first_q] == color_q[second_q]);
    assign last_pair    = ((32'(score_q) + 32'd1) == (NUM_TILES / 2));
    assign hold_done    = (hold_cnt == '0);

    // State register
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; start overrides everything, including a same-cycle pick
    always_comb begin
        state_d = state_q;
        if (bus.start) begin
            state_d = S_FIRST;
        end else begin
            case (state_q)
                S_IDLE:   state_d = S_IDLE;
                S_FIRST:  if (legal_pick) state_d = S_SECOND;
                S_SECOND: if (legal_pick) state_d = S_CMP;
                S_CMP:    state_d = colors_equal ? (last_pair ? S_OVER : S_FIRST) : S_HOLD;
                S_HOLD:   if (hold_done) state_d = S_FIRST;
                S_OVER:   state_d = S_OVER;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Game datapath: colour latch, tile masks, counters, hold timer and pulses
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TW; i++) color_q[i] <= '0;
            revealed_q    <= '0;
            matched_q     <= '0;
            first_q       <= '0;
            second_q      <= '0;
            score_q       <= '0;
            moves_q       <= '0;
            hold_cnt      <= '0;
            match_pulse_q <= 1'b0;
            miss_pulse_q  <= 1'b0;
        end else begin
            match_pulse_q <= 1'b0;
            miss_pulse_q  <= 1'b0;
            if (bus.start) begin
                for (int i = 0; i < TW; i++) color_q[i] <= colors_pad[i*COLOR_W +: COLOR_W];
                revealed_q <= '0;
                matched_q  <= '0;
                first_q    <= '0;
                second_q   <= '0;
                score_q    <= '0;
                moves_q    <= '0;
                hold_cnt   <= '0;
            end else begin
                case (state_q)
                    S_FIRST: begin
                        if (legal_pick) begin
                            first_q    <= bus.pick_idx;
                            revealed_q <= revealed_q | onehot(bus.pick_idx);
                        end
                    end
                    S_SECOND: begin
                        if (legal_pick) begin
                            second_q   <= bus.pick_idx;
                            revealed_q <= revealed_q | onehot(bus.pick_idx);
                            if (moves_q != '1) moves_q <= moves_q + 1'b1;
                        end
                    end
                    S_CMP: begin
                        if (colors_equal) begin
                            matched_q     <= matched_q | onehot(first_q) | onehot(second_q);
                            score_q       <= score_q + 1'b1;
                            match_pulse_q <= 1'b1;
                        end else begin
                            miss_pulse_q <= 1'b1;
                            hold_cnt     <= HOLD_W'(MISMATCH_HOLD - 1);
                        end
                    end
                    S_HOLD: begin
                        if (hold_done) revealed_q <= revealed_q & ~(onehot(first_q) | onehot(second_q));
                        else           hold_cnt   <= hold_cnt - 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Outputs, all taken straight from registers
    always_comb begin
        bus.game_state  = state_q;
        bus.game_over   = (state_q == S_OVER);
        bus.revealed    = revealed_q[NUM_TILES-1:0];
        bus.matched     = matched_q[NUM_TILES-1:0];
        bus.first_idx   = first_q;
        bus.second_idx  = second_q;
        bus.match_pulse = match_pulse_q;
        bus.miss_pulse  = miss_pulse_q;
        bus.score       = score_q;
        bus.moves       = moves_q;
    end
endmodule

// File: tb/tb_tile_match_engine.sv
// Directed bench for tile_match_engine with a short mismatch hold and the
// reference colour set 1,2,3,4,2,4,3,1,5,5 on tiles 0..9.
module tb_tile_match_engine;
    localparam int NUM_TILES = 10;
    localparam int COLOR_W   = 3;
    localparam int IDX_W     = 4;
    localparam int HOLD      = 4;
    localparam int CNT_W     = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    tile_match_if #(.NUM_TILES(NUM_TILES), .COLOR_W(COLOR_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

    tile_match_engine #(
        .NUM_TILES(NUM_TILES), .COLOR_W(COLOR_W), .IDX_W(IDX_W),
        .MISMATCH_HOLD(HOLD), .CNT_W(CNT_W)
    ) dut (
        .CLOCK_50(clk),
        .reset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pick(input int idx);
        bus.pick_valid = 1'b1;
        bus.pick_idx   = IDX_W'(idx);
        tick();
        bus.pick_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++; if (bus.game_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", bus.game_state); end
        n_checks++; if (bus.revealed !== 10'h000) begin n_fail++; $display("FAIL reset_revealed: got %0h expected 0", bus.revealed); end
        n_checks++; if (bus.matched !== 10'h000) begin n_fail++; $display("FAIL reset_matched: got %0h expected 0", bus.matched); end
        n_checks++; if ({bus.score, bus.moves} !== 16'h0000) begin n_fail++; $display("FAIL reset_counters: got %0h expected 0", {bus.score, bus.moves}); end
        n_checks++; if ({bus.match_pulse, bus.miss_pulse, bus.game_over} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {bus.match_pulse, bus.miss_pulse, bus.game_over}); end
        rst = 1'b0;
        tick();
        pick(0);
        n_checks++; if (bus.game_state !== 3'd0) begin n_fail++; $display("FAIL idle_ignores_pick: got %0d expected 0", bus.game_state); end
        pulse_start();
        n_checks++; if (bus.game_state !== 3'd1) begin n_fail++; $display("FAIL start_state: got %0d expected 1", bus.game_state); end
    endtask

    task automatic test_mismatch_hold();
        pick(0);
        n_checks++; if (bus.game_state !== 3'd2 || bus.first_idx !== 4'd0 || bus.revealed !== 10'h001) begin n_fail++; $display("FAIL first_pick: got state %0d idx %0d rev %0h expected 2 0 001", bus.game_state, bus.first_idx, bus.revealed); end
        pick(1);
        n_checks++; if (bus.game_state !== 3'd3 || bus.moves !== 8'd1 || bus.miss_pulse !== 1'b0) begin n_fail++; $display("FAIL compare_entry: got state %0d moves %0d miss %b expected 3 1 0", bus.game_state, bus.moves, bus.miss_pulse); end
        tick();
        n_checks++; if (bus.miss_pulse !== 1'b1 || bus.match_pulse !== 1'b0 || bus.game_state !== 3'd4) begin n_fail++; $display("FAIL miss_pulse: got miss %b match %b state %0d expected 1 0 4", bus.miss_pulse, bus.match_pulse, bus.game_state); end
        n_checks++; if (bus.revealed !== 10'h003) begin n_fail++; $display("FAIL hold_revealed: got %0h expected 003", bus.revealed); end
        pick(2);
        n_checks++; if (bus.game_state !== 3'd4 || bus.revealed !== 10'h003 || bus.miss_pulse !== 1'b0) begin n_fail++; $display("FAIL hold_pick_ignored: got state %0d rev %0h miss %b expected 4 003 0", bus.game_state, bus.revealed, bus.miss_pulse); end
        tick();
        tick();
        n_checks++; if (bus.game_state !== 3'd4 || bus.revealed !== 10'h003) begin n_fail++; $display("FAIL hold_last_cycle: got state %0d rev %0h expected 4 003", bus.game_state, bus.revealed); end
        tick();
        n_checks++; if (bus.game_state !== 3'd1 || bus.revealed !== 10'h000) begin n_fail++; $display("FAIL hold_expiry: got state %0d rev %0h expected 1 000", bus.game_state, bus.revealed); end
        n_checks++; if (bus.score !== 8'd0 || bus.moves !== 8'd1) begin n_fail++; $display("FAIL miss_counters: got score %0d moves %0d expected 0 1", bus.score, bus.moves); end
    endtask

    task automatic test_match();
        pick(0);
        pick(7);
        n_checks++; if (bus.match_pulse !== 1'b0 || bus.game_state !== 3'd3) begin n_fail++; $display("FAIL match_latency: got pulse %b state %0d expected 0 3", bus.match_pulse, bus.game_state); end
        tick();
        n_checks++; if (bus.match_pulse !== 1'b1 || bus.miss_pulse !== 1'b0) begin n_fail++; $display("FAIL match_pulse: got match %b miss %b expected 1 0", bus.match_pulse, bus.miss_pulse); end
        n_checks++; if (bus.matched !== 10'h081 || bus.score !== 8'd1 || bus.moves !== 8'd2 || bus.game_state !== 3'd1) begin n_fail++; $display("FAIL match_result: got m %0h s %0d mv %0d st %0d expected 081 1 2 1", bus.matched, bus.score, bus.moves, bus.game_state); end
        pick(0);
        n_checks++; if (bus.match_pulse !== 1'b0 || bus.game_state !== 3'd1) begin n_fail++; $display("FAIL matched_pick0: got pulse %b state %0d expected 0 1", bus.match_pulse, bus.game_state); end
        pick(7);
        n_checks++; if (bus.game_state !== 3'd1 || bus.revealed !== 10'h081) begin n_fail++; $display("FAIL matched_pick7: got state %0d rev %0h expected 1 081", bus.game_state, bus.revealed); end
    endtask

    task automatic test_illegal_picks();
        pick(2);
        pick(2);
        n_checks++; if (bus.game_state !== 3'd2 || bus.moves !== 8'd2) begin n_fail++; $display("FAIL repeat_pick: got state %0d moves %0d expected 2 2", bus.game_state, bus.moves); end
        pick(12);
        n_checks++; if (bus.game_state !== 3'd2 || bus.moves !== 8'd2 || bus.revealed !== 10'h085) begin n_fail++; $display("FAIL out_of_range_pick: got st %0d mv %0d rev %0h expected 2 2 085", bus.game_state, bus.moves, bus.revealed); end
        pick(6);
        tick();
        n_checks++; if (bus.matched !== 10'h0C5 || bus.score !== 8'd2 || bus.moves !== 8'd3) begin n_fail++; $display("FAIL pair_2_6: got m %0h s %0d mv %0d expected 0c5 2 3", bus.matched, bus.score, bus.moves); end
    endtask

    task automatic test_back_to_back();
        pick(1); pick(4); tick();
        pick(3); pick(5); tick();
        n_checks++; if (bus.score !== 8'd4 || bus.game_state !== 3'd1 || bus.game_over !== 1'b0) begin n_fail++; $display("FAIL four_pairs: got s %0d st %0d go %b expected 4 1 0", bus.score, bus.game_state, bus.game_over); end
        pick(8); pick(9); tick();
        n_checks++; if (bus.score !== 8'd5 || bus.matched !== 10'h3FF || bus.revealed !== 10'h3FF) begin n_fail++; $display("FAIL final_pair: got s %0d m %0h rev %0h expected 5 3ff 3ff", bus.score, bus.matched, bus.revealed); end
        n_checks++; if (bus.game_over !== 1'b1 || bus.game_state !== 3'd5 || bus.moves !== 8'd6) begin n_fail++; $display("FAIL game_over: got go %b st %0d mv %0d expected 1 5 6", bus.game_over, bus.game_state, bus.moves); end
        bus.start      = 1'b1;
        bus.pick_valid = 1'b1;
        bus.pick_idx   = 4'd0;
        tick();
        bus.start      = 1'b0;
        bus.pick_valid = 1'b0;
        n_checks++; if (bus.game_state !== 3'd1 || bus.revealed !== 10'h000 || bus.matched !== 10'h000) begin n_fail++; $display("FAIL restart_start_wins: got st %0d rev %0h m %0h expected 1 000 000", bus.game_state, bus.revealed, bus.matched); end
        n_checks++; if (bus.score !== 8'd0 || bus.moves !== 8'd0 || bus.game_over !== 1'b0) begin n_fail++; $display("FAIL restart_counters: got s %0d mv %0d go %b expected 0 0 0", bus.score, bus.moves, bus.game_over); end
    endtask

    task automatic test_reset_mid_hold();
        pick(0); pick(1); tick();
        n_checks++; if (bus.game_state !== 3'd4) begin n_fail++; $display("FAIL enter_hold: got %0d expected 4", bus.game_state); end
        rst = 1'b1;
        #1;
        n_checks++; if (bus.game_state !== 3'd0 || bus.revealed !== 10'h000 || bus.moves !== 8'd0 || bus.miss_pulse !== 1'b0) begin n_fail++; $display("FAIL async_reset: got st %0d rev %0h mv %0d miss %b expected 0 000 0 0", bus.game_state, bus.revealed, bus.moves, bus.miss_pulse); end
        tick();
        rst = 1'b0;
        tick();
        n_checks++; if (bus.game_state !== 3'd0 || {bus.match_pulse, bus.miss_pulse} !== 2'b00) begin n_fail++; $display("FAIL post_reset_quiet: got st %0d pulses %b expected 0 00", bus.game_state, {bus.match_pulse, bus.miss_pulse}); end
        pulse_start();
        pick(4); pick(1); tick();
        n_checks++; if (bus.match_pulse !== 1'b1 || bus.score !== 8'd1 || bus.moves !== 8'd1) begin n_fail++; $display("FAIL fresh_game: got pulse %b s %0d mv %0d expected 1 1 1", bus.match_pulse, bus.score, bus.moves); end
    endtask

    initial begin
        int colors [NUM_TILES] = '{1, 2, 3, 4, 2, 4, 3, 1, 5, 5};
        bus.start      = 1'b0;
        bus.pick_valid = 1'b0;
        bus.pick_idx   = '0;
        for (int i = 0; i < NUM_TILES; i++) bus.tile_colors[i*COLOR_W +: COLOR_W] = COLOR_W'(colors[i]);
        test_reset();
        test_mismatch_hold();
        test_match();
        test_illegal_picks();
        test_back_to_back();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
